// File: rtl/vec_mem_pkg.sv
// Shared types and default geometry for the vector MEM stage.
package vec_mem_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 16;
    localparam int RA_W   = 3;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    // Everything the W stage needs besides the two data vectors.
    typedef struct packed {
        logic            PCSrc;
        logic            RegWrite;
        logic            MemtoReg;
        logic [RA_W-1:0] WA3;
        logic            Oob;
    } mw_ctrl_t;

endpackage

// File: rtl/vec_mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the vector MEM stage.
interface vec_mem_stage_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 16,
    parameter int RA_W   = 3
);
    localparam int VW = LANES * LANE_W;

    logic              StallW;
    logic              FlushW;
    logic              PCSrcM;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic              MemWriteM;
    logic [LANES-1:0]  LaneMaskM;
    logic [VW-1:0]     ALUResultM;
    logic [VW-1:0]     WriteDataM;
    logic [RA_W-1:0]   WA3M;
    logic [ADDR_W-1:0] VGAArd;

    logic [VW-1:0]     ALUOutM;
    logic              PCSrcW;
    logic              RegWriteW;
    logic              MemtoRegW;
    logic [VW-1:0]     ReadDataW;
    logic [VW-1:0]     ALUOutW;
    logic [RA_W-1:0]   WA3W;
    logic              OobW;
    logic [VW-1:0]     VGAData;

    modport master (
        output StallW, FlushW, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
               LaneMaskM, ALUResultM, WriteDataM, WA3M, VGAArd,
        input  ALUOutM, PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW,
               WA3W, OobW, VGAData
    );

    modport slave (
        input  StallW, FlushW, PCSrcM, RegWriteM, MemtoRegM, MemWriteM,
               LaneMaskM, ALUResultM, WriteDataM, WA3M, VGAArd,
        output ALUOutM, PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW,
               WA3W, OobW, VGAData
    );

endinterface

// File: rtl/vec_ram_dp.sv
// Lane-masked dual-port vector RAM: port A read/write (write-first), port B read-only (read-first).
module vec_ram_dp #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int DEPTH  = 256,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_a_en,
    input  logic                         i_a_clr,
    input  logic [LANES-1:0]             i_a_we,
    input  logic [IW-1:0]                i_a_addr,
    input  logic [LANES-1:0][LANE_W-1:0] i_a_wdata,
    output logic [LANES-1:0][LANE_W-1:0] o_a_rdata,
    input  logic                         i_b_clr,
    input  logic [IW-1:0]                i_b_addr,
    output logic [LANES-1:0][LANE_W-1:0] o_b_rdata
);

    logic [LANES-1:0][LANE_W-1:0] r_mem [DEPTH];
    logic [LANES-1:0][LANE_W-1:0] r_a_rdata;
    logic [LANES-1:0][LANE_W-1:0] r_b_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (i_a_we[l]) r_mem[i_a_addr][l] <= i_a_wdata[l];
        end
    end

    // Output register holds while i_a_en is low; written lanes bypass the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata <= '0;
        end else if (i_a_clr) begin
            r_a_rdata <= '0;
        end else if (i_a_en) begin
            for (int l = 0; l < LANES; l++) begin
                r_a_rdata[l] <= i_a_we[l] ? i_a_wdata[l] : r_mem[i_a_addr][l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_b_rdata <= '0;
        else if (i_b_clr) r_b_rdata <= '0;
        else              r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/vec_mem_stage.sv
// Vector MEM stage with MEM/WB register: address range check, stall/flush, lane-masked stores.
module vec_mem_stage #(
    parameter int LANES  = vec_mem_pkg::LANES,
    parameter int LANE_W = vec_mem_pkg::LANE_W,
    parameter int DEPTH  = vec_mem_pkg::DEPTH,
    parameter int ADDR_W = vec_mem_pkg::ADDR_W,
    parameter int RA_W   = vec_mem_pkg::RA_W
) (
    input  logic            clk,
    input  logic            rst,
    vec_mem_stage_if.slave  bus
);
    import vec_mem_pkg::*;

    localparam int VW = LANES * LANE_W;
    localparam int IW = $clog2(DEPTH);

    logic                         w_adv;
    logic                         w_oob_m;
    logic                         w_oob_vga;
    logic [IW-1:0]                w_idx;
    logic [LANES-1:0]             w_we;
    logic [LANES-1:0][LANE_W-1:0] w_wdata;
    logic [LANES-1:0][LANE_W-1:0] w_rdata;
    logic [LANES-1:0][LANE_W-1:0] w_vga;
    mw_ctrl_t                     w_ctrl_m;
    mw_ctrl_t                     r_ctrl;
    logic [VW-1:0]                r_alu;

    // Address is a vector-word index; any set bit above the RAM index is out of range.
    assign w_oob_m   = |bus.ALUResultM[ADDR_W-1:IW];
    assign w_idx     = bus.ALUResultM[IW-1:0];
    assign w_oob_vga = |bus.VGAArd[ADDR_W-1:IW];
    assign w_adv     = !bus.StallW && !bus.FlushW;
    assign w_we      = (bus.MemWriteM && w_adv && !w_oob_m) ? bus.LaneMaskM : '0;
    assign w_wdata   = bus.WriteDataM;

    always_comb begin
        w_ctrl_m          = '0;
        w_ctrl_m.PCSrc    = bus.PCSrcM;
        w_ctrl_m.RegWrite = bus.RegWriteM;
        w_ctrl_m.MemtoReg = bus.MemtoRegM;
        w_ctrl_m.WA3      = bus.WA3M;
        w_ctrl_m.Oob      = w_oob_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_alu  <= '0;
        end else if (bus.FlushW) begin
            r_ctrl <= '0;
            r_alu  <= '0;
        end else if (w_adv) begin
            r_ctrl <= w_ctrl_m;
            r_alu  <= bus.ALUResultM;
        end
    end

    // The RAM's port-A output register is the ReadDataW stage register; flush and
    // out-of-range loads clear it instead of loading.
    vec_ram_dp #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_a_en    (w_adv),
        .i_a_clr   (bus.FlushW || (w_adv && w_oob_m)),
        .i_a_we    (w_we),
        .i_a_addr  (w_idx),
        .i_a_wdata (w_wdata),
        .o_a_rdata (w_rdata),
        .i_b_clr   (w_oob_vga),
        .i_b_addr  (bus.VGAArd[IW-1:0]),
        .o_b_rdata (w_vga)
    );

    assign bus.ALUOutM   = bus.ALUResultM;
    assign bus.PCSrcW    = r_ctrl.PCSrc;
    assign bus.RegWriteW = r_ctrl.RegWrite;
    assign bus.MemtoRegW = r_ctrl.MemtoReg;
    assign bus.WA3W      = r_ctrl.WA3;
    assign bus.OobW      = r_ctrl.Oob;
    assign bus.ALUOutW   = r_alu;
    assign bus.ReadDataW = w_rdata;
    assign bus.VGAData   = w_vga;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Randomised bench for vec_mem_stage against a word/lane-level memory model, plus directed literals.
module tb_vec_mem_stage;

    localparam int LANES = 8;
    localparam int LW    = 32;
    localparam int VW    = LANES * LW;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    vec_mem_stage_if #(.LANES(LANES), .LANE_W(LW), .ADDR_W(16), .RA_W(3)) bus ();

    vec_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic [LW-1:0] mm [DEPTH][LANES];
    logic          e_pc, e_rw, e_m2r, e_oob;
    logic [2:0]    e_wa3;
    logic [VW-1:0] e_alu, e_rd, e_vga;

    always @(posedge clk or posedge rst) begin : model
        int  idx, vidx;
        bit  oob, voob;
        if (rst) begin
            {e_pc, e_rw, e_m2r, e_oob, e_wa3} = '0;
            e_alu = '0; e_rd = '0; e_vga = '0;
        end else begin
            idx  = int'(bus.ALUResultM[7:0]);
            oob  = bus.ALUResultM[15:8] != 8'h0;
            vidx = int'(bus.VGAArd[7:0]);
            voob = bus.VGAArd[15:8] != 8'h0;
            for (int l = 0; l < LANES; l++) e_vga[l*LW +: LW] = voob ? '0 : mm[vidx][l];
            if (bus.FlushW) begin
                {e_pc, e_rw, e_m2r, e_oob, e_wa3} = '0;
                e_alu = '0; e_rd = '0;
            end else if (!bus.StallW) begin
                e_pc = bus.PCSrcM; e_rw = bus.RegWriteM; e_m2r = bus.MemtoRegM;
                e_wa3 = bus.WA3M; e_oob = oob; e_alu = bus.ALUResultM;
                for (int l = 0; l < LANES; l++) begin
                    if (oob)
                        e_rd[l*LW +: LW] = '0;
                    else if (bus.MemWriteM && bus.LaneMaskM[l])
                        e_rd[l*LW +: LW] = bus.WriteDataM[l*LW +: LW];
                    else
                        e_rd[l*LW +: LW] = mm[idx][l];
                end
                if (bus.MemWriteM && !oob)
                    for (int l = 0; l < LANES; l++)
                        if (bus.LaneMaskM[l]) mm[idx][l] = bus.WriteDataM[l*LW +: LW];
            end
        end
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : compare
        #1;
        if (chk_en) begin
            chk("ReadDataW", bus.ReadDataW, e_rd);
            chk("ALUOutW", bus.ALUOutW, e_alu);
            chk("ctrlW", VW'({bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.WA3W, bus.OobW}),
                VW'({e_pc, e_rw, e_m2r, e_wa3, e_oob}));
            chk("VGAData", bus.VGAData, e_vga);
            chk("ALUOutM", bus.ALUOutM, bus.ALUResultM);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = $urandom;
        return r;
    endfunction

    function automatic logic [15:0] rnd_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return {8'($urandom_range(1, 255)), 8'($urandom)};
        if (r < 4)  return 16'($urandom_range(0, 15));
        return 16'($urandom_range(0, 255));
    endfunction

    task automatic op(input bit we, input bit rw, input logic [7:0] mask, input logic [15:0] addr,
                      input logic [VW-1:0] wd, input bit stall, input bit flush, input logic [15:0] vga);
        logic [VW-1:0] a;
        a = rnd_vec();
        a[15:0] = addr;
        bus.MemWriteM  = we;
        bus.RegWriteM  = rw;
        bus.PCSrcM     = 1'($urandom);
        bus.MemtoRegM  = 1'($urandom);
        bus.WA3M       = 3'($urandom);
        bus.LaneMaskM  = mask;
        bus.ALUResultM = a;
        bus.WriteDataM = wd;
        bus.StallW     = stall;
        bus.FlushW     = flush;
        bus.VGAArd     = vga;
        @(negedge clk);
    endtask

    logic [VW-1:0] exp_v, exp_a;

    initial begin
        bus.MemWriteM = 0; bus.RegWriteM = 0; bus.PCSrcM = 0; bus.MemtoRegM = 0;
        bus.WA3M = 0; bus.LaneMaskM = 0; bus.ALUResultM = 0; bus.WriteDataM = 0;
        bus.StallW = 0; bus.FlushW = 0; bus.VGAArd = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation
        op(1, 1, 8'hFF, 16'd3, {8{32'h5A5A5A5A}}, 0, 0, 16'd3);
        chk("pre_rst_RegWriteW", VW'(bus.RegWriteW), VW'(1));
        chk("pre_rst_ReadDataW", bus.ReadDataW, {8{32'h5A5A5A5A}});
        rst = 1'b1;
        #1;
        chk("rst_ReadDataW", bus.ReadDataW, '0);
        chk("rst_ALUOutW", bus.ALUOutW, '0);
        chk("rst_ctrlW", VW'({bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.WA3W, bus.OobW}), '0);
        chk("rst_VGAData", bus.VGAData, '0);
        @(negedge clk);
        rst = 1'b0;

        // Fill the whole RAM so the model knows every word
        for (int i = 0; i < DEPTH; i++) op(1, 0, 8'hFF, 16'(i), rnd_vec(), 0, 0, 16'(i));
        chk_en = 1'b1;

        op(1, 0, 8'hFF, 16'd0, {8{32'h0BADBEEF}}, 0, 0, 16'd0);

        // Masked store then load
        op(1, 0, 8'hFF, 16'd5, {8{32'hAAAAAAAA}}, 0, 0, 16'd0);
        op(1, 0, 8'h05, 16'd5, {8{32'h12345678}}, 0, 0, 16'd0);
        op(0, 1, 8'h00, 16'd5, '0, 0, 0, 16'd0);
        exp_a = {8{32'hAAAAAAAA}};
        exp_a[31:0]  = 32'h12345678;
        exp_a[95:64] = 32'h12345678;
        chk("mask_load", bus.ReadDataW, exp_a);

        // Same-cycle store/load (write-first) with VGA read-first
        op(1, 0, 8'hFF, 16'd7, '0, 0, 0, 16'd0);
        op(1, 0, 8'h0F, 16'd7, {8{32'hCAFEF00D}}, 0, 0, 16'd7);
        exp_v = '0;
        exp_v[127:0] = {4{32'hCAFEF00D}};
        chk("wr_first", bus.ReadDataW, exp_v);
        chk("vga_rd_first", bus.VGAData, '0);

        // Stall: W frozen, store commits on release
        op(1, 0, 8'hFF, 16'd9, {8{32'h11111111}}, 0, 0, 16'd0);
        op(0, 1, 8'h00, 16'd5, '0, 0, 0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            op(1, 1, 8'hFF, 16'd9, {8{32'hD1D1D1D1}}, 1, 0, 16'd9);
            chk("stall_hold", bus.ReadDataW, exp_a);
            chk("stall_nowrite", bus.VGAData, {8{32'h11111111}});
        end
        op(1, 1, 8'hFF, 16'd9, {8{32'hD1D1D1D1}}, 0, 0, 16'd9);
        chk("stall_release", bus.ReadDataW, {8{32'hD1D1D1D1}});
        op(0, 0, 8'h00, 16'd1, '0, 0, 0, 16'd9);
        chk("stall_commit", bus.VGAData, {8{32'hD1D1D1D1}});

        // Flush with stall: bubble, no write
        op(1, 1, 8'hFF, 16'd9, {8{32'hE2E2E2E2}}, 1, 1, 16'd9);
        chk("flush_rd", bus.ReadDataW, '0);
        chk("flush_alu", bus.ALUOutW, '0);
        chk("flush_ctrl", VW'({bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.WA3W, bus.OobW}), '0);
        op(0, 0, 8'h00, 16'd1, '0, 0, 0, 16'd9);
        chk("flush_nowrite", bus.VGAData, {8{32'hD1D1D1D1}});

        // Out of range
        op(1, 0, 8'hFF, 16'h0100, {8{32'hF3F3F3F3}}, 0, 0, 16'd0);
        chk("oob_st_flag", VW'(bus.OobW), VW'(1));
        chk("oob_st_rd", bus.ReadDataW, '0);
        op(0, 1, 8'h00, 16'h0100, '0, 0, 0, 16'd0);
        chk("oob_ld_flag", VW'(bus.OobW), VW'(1));
        chk("oob_ld_rd", bus.ReadDataW, '0);
        chk("oob_idx0_kept", bus.VGAData, {8{32'h0BADBEEF}});
        op(0, 0, 8'h00, 16'd1, '0, 0, 0, 16'h0100);
        chk("oob_vga", bus.VGAData, '0);

        // Randomised traffic
        for (int n = 0; n < 2000; n++)
            op(1'($urandom), 1'($urandom), 8'($urandom), rnd_addr(), rnd_vec(),
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rnd_addr());
        op(0, 0, 8'h00, 16'd0, '0, 0, 0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
